// File: rtl/key_event_queue.sv
// Edge-detects four direction keys into 2-bit move codes queued in a DEPTH-entry FIFO.
// A push is written at the sampling clock, so codes are visible one cycle later. When the FIFO is full, edges are dropped and counted unless a pop happens in the same cycle.
module key_event_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 8
) (
    input  logic          CLK,
    input  logic          ACLR,
    input  logic [3:0]    KEY_IN,
    input  logic          EV_READY,
    output logic          EV_VALID,
    output logic [1:0]    EV_CODE,
    output logic [AW:0]   EV_COUNT,
    output logic          OVF,
    output logic [CW-1:0] DROP_CNT
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [3:0]    prev;
    logic [3:0]    edges;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          cand;
    logic [1:0]    cand_code;
    logic [2:0]    n_edges;
    logic [2:0]    n_drop;
    logic          full;
    logic          pop;
    logic          push;
    logic [CW:0]   drop_sum;

    always_comb begin
        edges     = KEY_IN & ~prev;
        cand      = |edges;
        cand_code = 2'b00;
        if (edges[0])      cand_code = 2'b00;
        else if (edges[1]) cand_code = 2'b01;
        else if (edges[2]) cand_code = 2'b10;
        else if (edges[3]) cand_code = 2'b11;
        n_edges  = 3'(edges[0]) + 3'(edges[1]) + 3'(edges[2]) + 3'(edges[3]);
        full     = (EV_COUNT == FULL_CNT);
        pop      = EV_VALID & EV_READY;
        // A full FIFO still takes the winner when the head leaves this cycle.
        push     = cand & (~full | pop);
        n_drop   = n_edges - 3'(cand) + 3'(cand & ~push);
        drop_sum = {1'b0, DROP_CNT} + (CW+1)'(n_drop);
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            prev     <= 4'b0000;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            EV_COUNT <= '0;
            OVF      <= 1'b0;
            DROP_CNT <= '0;
        end else begin
            prev <= KEY_IN;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   EV_COUNT <= EV_COUNT + (AW+1)'(1);
                2'b01:   EV_COUNT <= EV_COUNT - (AW+1)'(1);
                default: EV_COUNT <= EV_COUNT;
            endcase
            if (n_drop != 3'd0) begin
                OVF      <= 1'b1;
                DROP_CNT <= drop_sum[CW] ? {CW{1'b1}} : drop_sum[CW-1:0];
            end
        end
    end

    // Storage needs no reset: EV_CODE is masked whenever the queue is empty.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= cand_code;
    end

    assign EV_VALID = (EV_COUNT != '0);
    assign EV_CODE  = EV_VALID ? mem[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus random traffic against a queue-based model.
module tb_key_event_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 8;

    logic          CLK = 1'b0;
    logic          ACLR;
    logic [3:0]    KEY_IN;
    logic          EV_READY;
    logic          EV_VALID;
    logic [1:0]    EV_CODE;
    logic [AW:0]   EV_COUNT;
    logic          OVF;
    logic [CW-1:0] DROP_CNT;
    logic [15:0]   obs;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of accepted codes, previous key levels, drop tally.
    int       mq[$];
    logic [3:0] mprev;
    int       mdrop;
    bit       movf;

    key_event_queue #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .CLK(CLK), .ACLR(ACLR), .KEY_IN(KEY_IN), .EV_READY(EV_READY),
        .EV_VALID(EV_VALID), .EV_CODE(EV_CODE), .EV_COUNT(EV_COUNT),
        .OVF(OVF), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    assign obs = {EV_VALID, EV_CODE, EV_COUNT, OVF, DROP_CNT};

    function automatic logic [15:0] expv();
        logic       v;
        logic [1:0] c;
        v = (mq.size() != 0);
        c = v ? 2'(mq[0]) : 2'b00;
        return {v, c, 4'(mq.size()), movf, 8'(mdrop)};
    endfunction

    task automatic model_clear();
        mq.delete();
        mprev = 4'b0000;
        mdrop = 0;
        movf  = 1'b0;
    endtask

    task automatic model_drop();
        movf = 1'b1;
        if (mdrop < 255) mdrop++;
    endtask

    task automatic model_step(input logic [3:0] k, input logic r);
        bit popped;
        bit won;
        int code;
        popped = (mq.size() != 0) && r;
        won    = 1'b0;
        code   = 0;
        for (int i = 0; i < 4; i++) begin
            if (k[i] && !mprev[i]) begin
                if (!won) begin
                    won  = 1'b1;
                    code = i;
                end else begin
                    model_drop();
                end
            end
        end
        if (popped) void'(mq.pop_front());
        if (won) begin
            if (mq.size() < DEPTH) mq.push_back(code);
            else model_drop();
        end
        mprev = k;
    endtask

    // Drive inputs, take one clock, advance the model, settle 1 ns past the edge.
    task automatic cycle(input logic [3:0] k, input logic r);
        KEY_IN   = k;
        EV_READY = r;
        @(posedge CLK);
        model_step(k, r);
        #1;
    endtask

    task automatic do_reset();
        ACLR     = 1'b1;
        KEY_IN   = 4'b0000;
        EV_READY = 1'b0;
        @(posedge CLK);
        #1;
        ACLR = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        ACLR     = 1'b1;
        KEY_IN   = 4'b0000;
        EV_READY = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", obs, 16'h0000);
        end
        @(posedge CLK);
        #1;
        ACLR = 1'b0;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0001, 1'b0);
            n_cmp++;
            if (obs !== expv()) begin
                n_bad++;
                $display("FAIL hold c%0d: got %h want %h", i, obs, expv());
            end
        end
        n_cmp++;
        if ({EV_VALID, EV_CODE, EV_COUNT} !== {1'b1, 2'b00, 4'd1}) begin
            n_bad++;
            $display("FAIL hold_single: got v=%b c=%b n=%0d want v=1 c=00 n=1", EV_VALID, EV_CODE, EV_COUNT);
        end
        cycle(4'b0000, 1'b1);
        n_cmp++;
        if (obs !== expv()) begin
            n_bad++;
            $display("FAIL hold_drain: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_sequence();
        logic [3:0] keys [3];
        logic [1:0] want [3];
        keys = '{4'b1000, 4'b0100, 4'b0010};
        want = '{2'b11, 2'b10, 2'b01};
        for (int i = 0; i < 3; i++) begin
            cycle(keys[i], 1'b0);
            cycle(4'b0000, 1'b0);
            n_cmp++;
            if (obs !== expv()) begin
                n_bad++;
                $display("FAIL seq_fill p%0d: got %h want %h", i, obs, expv());
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (EV_VALID !== 1'b1 || EV_CODE !== want[i]) begin
                n_bad++;
                $display("FAIL seq_order r%0d: got v=%b c=%b want v=1 c=%b", i, EV_VALID, EV_CODE, want[i]);
            end
            cycle(4'b0000, 1'b1);
        end
        n_cmp++;
        if (EV_VALID !== 1'b0 || EV_COUNT !== 4'd0) begin
            n_bad++;
            $display("FAIL seq_empty: got v=%b n=%0d want v=0 n=0", EV_VALID, EV_COUNT);
        end
    endtask

    task automatic test_multi_edge();
        cycle(4'b1111, 1'b0);
        n_cmp++;
        if (obs !== expv()) begin
            n_bad++;
            $display("FAIL multi_model: got %h want %h", obs, expv());
        end
        n_cmp++;
        if ({EV_CODE, EV_COUNT, OVF, DROP_CNT} !== {2'b00, 4'd1, 1'b1, 8'd3}) begin
            n_bad++;
            $display("FAIL multi_edge: got c=%b n=%0d ovf=%b drop=%0d want c=00 n=1 ovf=1 drop=3",
                     EV_CODE, EV_COUNT, OVF, DROP_CNT);
        end
        cycle(4'b1111, 1'b0);
        cycle(4'b0000, 1'b1);
        n_cmp++;
        if (obs !== expv()) begin
            n_bad++;
            $display("FAIL multi_drain: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(4'(1 << $urandom_range(0, 3)), 1'b0);
            cycle(4'b0000, 1'b0);
            n_cmp++;
            if (obs !== expv()) begin
                n_bad++;
                $display("FAIL full_fill p%0d: got %h want %h", i, obs, expv());
            end
        end
        n_cmp++;
        if ({EV_COUNT, OVF, DROP_CNT} !== {4'd8, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL full_drop: got n=%0d ovf=%b drop=%0d want n=8 ovf=1 drop=1", EV_COUNT, OVF, DROP_CNT);
        end
        cycle(4'(1 << $urandom_range(0, 3)), 1'b1);
        n_cmp++;
        if (EV_COUNT !== 4'd8 || DROP_CNT !== 8'd1) begin
            n_bad++;
            $display("FAIL full_pushpop: got n=%0d drop=%0d want n=8 drop=1", EV_COUNT, DROP_CNT);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs !== expv()) begin
                n_bad++;
                $display("FAIL full_drain r%0d: got %h want %h", i, obs, expv());
            end
            cycle(4'b0000, 1'b1);
        end
        n_cmp++;
        if (EV_COUNT !== 4'd0 || EV_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL full_empty: got n=%0d v=%b want n=0 v=0", EV_COUNT, EV_VALID);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            cycle(4'(1 << $urandom_range(0, 3)), 1'b0);
            cycle(4'b0000, 1'b0);
        end
        n_cmp++;
        if (obs !== expv()) begin
            n_bad++;
            $display("FAIL rmid_fill: got %h want %h", obs, expv());
        end
        ACLR   = 1'b1;
        KEY_IN = 4'b0100;
        #1;
        model_clear();
        n_cmp++;
        if (EV_COUNT !== 4'd0 || OVF !== 1'b0 || EV_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_async: got n=%0d ovf=%b v=%b want n=0 ovf=0 v=0", EV_COUNT, OVF, EV_VALID);
        end
        @(posedge CLK);
        #1;
        ACLR = 1'b0;
        cycle(4'b0100, 1'b0);
        n_cmp++;
        if (obs !== expv() || EV_CODE !== 2'b10 || EV_COUNT !== 4'd1) begin
            n_bad++;
            $display("FAIL rmid_left: got %h want %h (code 10, count 1)", obs, expv());
        end
        cycle(4'b0000, 1'b1);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 100; i++) begin
            cycle(4'b1111, 1'b0);
            cycle(4'b0000, 1'b0);
            n_cmp++;
            if (obs !== expv()) begin
                n_bad++;
                $display("FAIL sat i%0d: got %h want %h", i, obs, expv());
            end
        end
        n_cmp++;
        if (DROP_CNT !== 8'hFF || OVF !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_hold: got drop=%0d ovf=%b want drop=255 ovf=1", DROP_CNT, OVF);
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        logic       r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            k = 4'($urandom) & 4'($urandom);
            if (i < 1500) r = ($urandom_range(0, 3) == 0);
            else          r = ($urandom_range(0, 3) != 0);
            cycle(k, r);
            n_cmp++;
            if (obs !== expv()) begin
                n_bad++;
                $display("FAIL random c%0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    initial begin
        ACLR     = 1'b1;
        KEY_IN   = 4'b0000;
        EV_READY = 1'b0;
        test_reset();
        test_hold();
        test_sequence();
        test_multi_edge();
        test_full();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Consumer end of the debounced-switch interface.
- Takes the four debounced direction-key levels and detects a rising edge on each, turning every press into exactly one 2-bit move code.
- Buffers the codes in a small FIFO and presents them to the maze game logic over a valid/ready handshake, so presses arriving while the game logic is busy are not lost.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
AW, 3, pointer width; equals log2(DEPTH)
CW, 8, width of saturating drop counter

Ports:
CLK  input  1  system clock; all logic on rising edge
ACLR  input  1  asynchronous reset, active-high
KEY_IN  input  4  debounced key levels, synchronous to CLK; bit0=UP, bit1=DOWN, bit2=LEFT, bit3=RIGHT; a press may stay high for several CLK cycles
EV_READY  input  1  consumer accepts the head entry this cycle
EV_VALID  output  1  FIFO non-empty; EV_CODE is valid
EV_CODE  output  2  head move code: 00=UP, 01=DOWN, 10=LEFT, 11=RIGHT
EV_COUNT  output  AW+1  entries currently held, 0..DEPTH
OVF  output  1  sticky: at least one event was dropped since reset
DROP_CNT  output  CW  number of dropped events, saturating at all-ones

Behaviour:
- Reset (ACLR high, asynchronous):
  - Pointers, EV_COUNT, OVF and DROP_CNT go to 0; EV_VALID=0; EV_CODE=00.
  - Edge-detect history register goes to 4'b0000, so a key already held high at reset release produces an event on the first clock.
  - Reset mid-operation discards all queued entries.
- Edge detect:
  - edge[i] = KEY_IN[i] & ~prev[i]; prev <= KEY_IN every cycle.
  - A level held high for N cycles yields exactly one edge.
  - A level that drops and rises again yields a new edge.
- Arbitration when several edges occur in one cycle:
  - Priority is UP > DOWN > LEFT > RIGHT; only the winner is a push candidate.
  - Each losing edge counts as a drop: DROP_CNT += number of losers, saturating. OVF is set.
- Push/pop, evaluated in the same cycle:
  - pop = EV_VALID & EV_READY.
  - push_ok = candidate & (EV_COUNT < DEPTH | pop). A full FIFO accepts a push when a pop happens in the same cycle.
  - A candidate rejected because the FIFO is full counts as one drop and sets OVF, in addition to any arbitration drops.
  - EV_COUNT: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency and ordering:
  - An edge sampled at clock k is written at k.
  - On an empty FIFO, EV_VALID and EV_CODE assert after clock k (visible in cycle k+1). There is no combinational fall-through from KEY_IN.
  - EV_CODE shows the head entry and is stable while EV_VALID=1 and EV_READY=0.
  - Output order equals acceptance order (FIFO).
- Pointers:
  - Read and write pointers are AW bits and wrap modulo DEPTH.
  - Full/empty are derived from EV_COUNT, not from pointer compare.
- Registered outputs: EV_VALID = (EV_COUNT != 0); EV_CODE comes from the read port at rd_ptr.
- EV_READY while EV_VALID=0 is ignored: no pointer or count change.
- OVF and DROP_CNT are cleared only by ACLR. DROP_CNT holds at 2^CW-1 once saturated.
- State machine: none beyond the FIFO. Control state is {prev, wr_ptr, rd_ptr, EV_COUNT, OVF, DROP_CNT}.

Test Plan:
- Reset then hold KEY_IN=0001 for 4 cycles, EV_READY=0 -> exactly one entry; EV_VALID=1 from the cycle after the first edge; EV_CODE=00; EV_COUNT=1.
- Press RIGHT, LEFT, DOWN in separate pulses, then EV_READY=1 for 3 cycles -> EV_CODE sequence 11, 10, 01; EV_COUNT returns to 0; EV_VALID=0 afterwards.
- KEY_IN jumps 0000->1111 in one cycle -> one entry with code 00; DROP_CNT=3; OVF=1.
- EV_READY=0, 9 separate presses with DEPTH=8 -> EV_COUNT=8; 9th press dropped; DROP_CNT=1; OVF=1; the first 8 codes read out in order.
- FIFO full and EV_READY=1 on the same cycle as a new edge -> push accepted; EV_COUNT stays 8; DROP_CNT unchanged; new code appears last after wrap-around.
- Queue 5 entries, assert ACLR for 1 cycle with KEY_IN held 0100 -> EV_COUNT=0 and OVF=0 immediately; after release one LEFT entry (10) appears on the first clock.
